// File: rtl/dm_cache_pkg.sv
// Shared definitions for the direct-mapped data cache controller.
//   - FSM state encoding
//   - default geometry (index / tag widths) and the cacheable address bound
//   - byte-strobe merge helper used by the line store
package dm_cache_pkg;

    localparam int          IDX_W       = 6;
    localparam int          TAG_W       = 30 - IDX_W;
    localparam logic [31:0] CACHE_LIMIT = 32'h0000_1000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Replace the bytes of old_word selected by strb with the bytes of new_word.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_word;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_word[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/dm_cache_if.sv
// Bus bundle around the cache controller.
//   mem_* : PicoRV32 native memory port (core side).
//   bk_*  : valid/ready port towards the slower backing memory.
// Modports:
//   slave  : the cache controller view (accepts core requests, drives backing requests).
//   master : the environment view (core plus backing memory).
interface dm_cache_if;

    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    logic        bk_valid;
    logic [31:0] bk_addr;
    logic [31:0] bk_wdata;
    logic [3:0]  bk_wstrb;
    logic        bk_ready;
    logic [31:0] bk_rdata;

    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata,
        output bk_valid, bk_addr, bk_wdata, bk_wstrb,
        input  bk_ready, bk_rdata
    );

    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata,
        input  bk_valid, bk_addr, bk_wdata, bk_wstrb,
        output bk_ready, bk_rdata
    );

endinterface

// File: rtl/dm_cache_store.sv
// Tag / data / valid arrays of the direct-mapped cache.
// Ports:
//   clk, rst         clock, synchronous active-high reset (clears valid bits only)
//   clr              flash-clear of every valid bit
//   rd_idx           combinational read index -> rd_valid, rd_tag, rd_data
//   wr_en            synchronous line write at wr_idx: stores wr_tag, merges
//                    wr_data into the line under wr_strb and sets the valid bit
module dm_cache_store
    import dm_cache_pkg::*;
#(
    parameter int LINES = 64,
    parameter int IDX_W = dm_cache_pkg::IDX_W,
    parameter int TAG_W = dm_cache_pkg::TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [31:0]      rd_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [31:0]      wr_data,
    input  logic [3:0]       wr_strb
);

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tags [LINES];
    logic [31:0]      data [LINES];

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tags[rd_idx];
    assign rd_data  = data[rd_idx];

    // A clear wins over a simultaneous write so a flush never leaves a line valid.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    // Tag and data carry no reset; they are meaningless while the valid bit is low.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_idx] <= wr_tag;
            data[wr_idx] <= merge_bytes(data[wr_idx], wr_data, wr_strb);
        end
    end

endmodule

// File: rtl/dm_cache_ctrl.sv
// Sequencing controller for a direct-mapped, one-word-per-line data cache between
// the PicoRV32 native memory port and a backing memory.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   bus             dm_cache_if.slave: core request port (mem_*) and backing port (bk_*)
//   flush           pulse: invalidate every line (deferred to IDLE if busy)
//   hit_count       cached read hits (wraps)
//   miss_count      cached read misses (wraps)
// Reads that hit complete one cycle after acceptance; misses fill from backing
// memory. Writes are write-through with byte merge on hit and no allocate on miss.
module dm_cache_ctrl
    import dm_cache_pkg::*;
#(
    parameter int          LINES       = 64,
    parameter int          IDX_W       = dm_cache_pkg::IDX_W,
    parameter logic [31:0] CACHE_LIMIT = dm_cache_pkg::CACHE_LIMIT
) (
    input  logic        clk,
    input  logic        rst,
    dm_cache_if.slave   bus,
    input  logic        flush,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int TAG_W = 30 - IDX_W;

    state_t      state, state_nxt;
    logic        flush_pend, flush_pend_nxt;
    logic        mem_ready_r, mem_ready_nxt;
    logic [31:0] mem_rdata_r, mem_rdata_nxt;
    logic        bk_valid_r, bk_valid_nxt;
    logic [31:0] bk_addr_r, bk_addr_nxt;
    logic [31:0] bk_wdata_r, bk_wdata_nxt;
    logic [3:0]  bk_wstrb_r, bk_wstrb_nxt;
    logic [31:0] hit_r, hit_nxt;
    logic [31:0] miss_r, miss_nxt;

    logic             st_clr;
    logic             st_rd_valid;
    logic [TAG_W-1:0] st_rd_tag;
    logic [31:0]      st_rd_data;
    logic             st_wr_en;
    logic [IDX_W-1:0] st_wr_idx;
    logic [TAG_W-1:0] st_wr_tag;
    logic [31:0]      st_wr_data;
    logic [3:0]       st_wr_strb;

    // Fetches are served exactly like data reads.
    logic unused_instr;
    assign unused_instr = bus.mem_instr;

    // Request decode straight from the core port (stable while mem_valid is high).
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic             req_cached;
    logic             req_hit;
    logic             req_read;

    assign req_idx    = bus.mem_addr[IDX_W+1:2];
    assign req_tag    = bus.mem_addr[31:IDX_W+2];
    assign req_cached = (bus.mem_addr < CACHE_LIMIT);
    assign req_read   = (bus.mem_wstrb == 4'b0000);
    assign req_hit    = req_cached && st_rd_valid && (st_rd_tag == req_tag);

    // Fill decode from the registered backing address, which is held for the
    // whole FILL state independently of the core port.
    logic [IDX_W-1:0] fill_idx;
    logic [TAG_W-1:0] fill_tag;
    logic             fill_cached;

    assign fill_idx    = bk_addr_r[IDX_W+1:2];
    assign fill_tag    = bk_addr_r[31:IDX_W+2];
    assign fill_cached = (bk_addr_r < CACHE_LIMIT);

    dm_cache_store #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_store (
        .clk      (clk),
        .rst      (rst),
        .clr      (st_clr),
        .rd_idx   (req_idx),
        .rd_valid (st_rd_valid),
        .rd_tag   (st_rd_tag),
        .rd_data  (st_rd_data),
        .wr_en    (st_wr_en),
        .wr_idx   (st_wr_idx),
        .wr_tag   (st_wr_tag),
        .wr_data  (st_wr_data),
        .wr_strb  (st_wr_strb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            flush_pend  <= 1'b0;
            mem_ready_r <= 1'b0;
            mem_rdata_r <= '0;
            bk_valid_r  <= 1'b0;
            bk_addr_r   <= '0;
            bk_wdata_r  <= '0;
            bk_wstrb_r  <= '0;
            hit_r       <= '0;
            miss_r      <= '0;
        end else begin
            state       <= state_nxt;
            flush_pend  <= flush_pend_nxt;
            mem_ready_r <= mem_ready_nxt;
            mem_rdata_r <= mem_rdata_nxt;
            bk_valid_r  <= bk_valid_nxt;
            bk_addr_r   <= bk_addr_nxt;
            bk_wdata_r  <= bk_wdata_nxt;
            bk_wstrb_r  <= bk_wstrb_nxt;
            hit_r       <= hit_nxt;
            miss_r      <= miss_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        flush_pend_nxt = flush_pend;
        mem_ready_nxt  = mem_ready_r;
        mem_rdata_nxt  = mem_rdata_r;
        bk_valid_nxt   = bk_valid_r;
        bk_addr_nxt    = bk_addr_r;
        bk_wdata_nxt   = bk_wdata_r;
        bk_wstrb_nxt   = bk_wstrb_r;
        hit_nxt        = hit_r;
        miss_nxt       = miss_r;

        st_clr     = 1'b0;
        st_wr_en   = 1'b0;
        st_wr_idx  = req_idx;
        st_wr_tag  = req_tag;
        st_wr_data = bus.mem_wdata;
        st_wr_strb = bus.mem_wstrb;

        unique case (state)
            IDLE: begin
                if (flush_pend || flush) begin
                    // Flush takes the cycle; a waiting request is accepted next cycle.
                    st_clr         = 1'b1;
                    flush_pend_nxt = 1'b0;
                end else if (bus.mem_valid) begin
                    if (req_read && req_hit) begin
                        mem_rdata_nxt = st_rd_data;
                        mem_ready_nxt = 1'b1;
                        hit_nxt       = hit_r + 32'd1;
                        state_nxt     = DONE;
                    end else if (req_read) begin
                        bk_valid_nxt = 1'b1;
                        bk_addr_nxt  = {bus.mem_addr[31:2], 2'b00};
                        bk_wstrb_nxt = 4'b0000;
                        if (req_cached) miss_nxt = miss_r + 32'd1;
                        state_nxt    = FILL;
                    end else begin
                        bk_valid_nxt = 1'b1;
                        bk_addr_nxt  = {bus.mem_addr[31:2], 2'b00};
                        bk_wdata_nxt = bus.mem_wdata;
                        bk_wstrb_nxt = bus.mem_wstrb;
                        // Write-through: merge into the line only when it already holds this address.
                        st_wr_en     = req_hit;
                        state_nxt    = WRITE;
                    end
                end
            end
            FILL: begin
                if (flush) flush_pend_nxt = 1'b1;
                if (bus.bk_ready) begin
                    bk_valid_nxt  = 1'b0;
                    mem_rdata_nxt = bus.bk_rdata;
                    mem_ready_nxt = 1'b1;
                    state_nxt     = DONE;
                    st_wr_en      = fill_cached;
                    st_wr_idx     = fill_idx;
                    st_wr_tag     = fill_tag;
                    st_wr_data    = bus.bk_rdata;
                    st_wr_strb    = 4'b1111;
                end
            end
            WRITE: begin
                if (flush) flush_pend_nxt = 1'b1;
                if (bus.bk_ready) begin
                    bk_valid_nxt  = 1'b0;
                    mem_ready_nxt = 1'b1;
                    state_nxt     = DONE;
                end
            end
            DONE: begin
                if (flush) flush_pend_nxt = 1'b1;
                mem_ready_nxt = 1'b0;
                state_nxt     = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.mem_ready = mem_ready_r;
    assign bus.mem_rdata = mem_rdata_r;
    assign bus.bk_valid  = bk_valid_r;
    assign bus.bk_addr   = bk_addr_r;
    assign bus.bk_wdata  = bk_wdata_r;
    assign bus.bk_wstrb  = bk_wstrb_r;
    assign hit_count     = hit_r;
    assign miss_count    = miss_r;

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Bench for dm_cache_ctrl: directed scenarios followed by randomized traffic,
// checked against a line-level model of a write-through direct-mapped cache.
module tb_dm_cache_ctrl;

    localparam logic [31:0] LIMIT = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    dm_cache_if bus();

    dm_cache_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .flush      (flush),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: which word each line holds, backing memory contents, counters.
    bit          mv [64];
    logic [23:0] mt [64];
    logic [31:0] bmem [logic [31:0]];
    logic [31:0] mhit  = 0;
    logic [31:0] mmiss = 0;
    logic [31:0] last_rdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 64; i++) mv[i] = 1'b0;
    endtask

    task automatic check_counters();
        check("hit_count", hit_count, mhit);
        check("miss_count", miss_count, mmiss);
    endtask

    // One core transaction with a backing memory answering lat cycles after bk_valid.
    task automatic txn(input logic [31:0] addr, input logic [3:0] strb,
                       input logic [31:0] wdata, input int lat, input bit flush_mid);
        logic [31:0] w;
        bit          wr, cached, exp_hit, got, seen_bk, flushed;
        int          idx, n, bkc;
        logic [23:0] tag;
        logic [31:0] exp_rdata;
        w       = {addr[31:2], 2'b00};
        wr      = (strb != 4'b0000);
        cached  = (w < LIMIT);
        idx     = int'(w[7:2]);
        tag     = w[31:8];
        exp_hit = !wr && cached && mv[idx] && (mt[idx] == tag);
        if (!bmem.exists(w)) bmem[w] = $urandom;
        exp_rdata = bmem[w];

        bus.mem_valid = 1'b1;
        bus.mem_instr = $urandom_range(0, 1);
        bus.mem_addr  = addr;
        bus.mem_wdata = wdata;
        bus.mem_wstrb = strb;
        n = 0; bkc = 0; got = 0; seen_bk = 0; flushed = 0;
        while (!got && n < 60) begin
            @(negedge clk);
            n++;
            bus.bk_ready = 1'b0;
            flush = 1'b0;
            if (bus.mem_ready) begin
                got = 1;
            end else if (bus.bk_valid) begin
                if (!seen_bk) begin
                    seen_bk = 1;
                    check("bk_addr", bus.bk_addr, w);
                    check("bk_wstrb", 32'(bus.bk_wstrb), 32'(strb));
                    if (wr) check("bk_wdata", bus.bk_wdata, wdata);
                    if (flush_mid) begin
                        flush = 1'b1;
                        flushed = 1;
                    end
                end
                if (bkc == lat) begin
                    bus.bk_ready = 1'b1;
                    bus.bk_rdata = bmem[w];
                end
                bkc++;
            end
        end
        check("completed", 32'(got), 32'd1);
        if (got) begin
            check("bk_used", 32'(seen_bk), 32'(!exp_hit));
            if (exp_hit) check("hit_latency", 32'(n), 32'd1);
            if (!wr) check("mem_rdata", bus.mem_rdata, exp_rdata);
            last_rdata = bus.mem_rdata;
        end
        bus.mem_valid = 1'b0;
        bus.mem_wstrb = 4'b0000;
        @(negedge clk);
        check("ready_width", 32'(bus.mem_ready), 32'd0);

        if (wr) bmem[w] = merge(bmem[w], wdata, strb);
        if (!wr && cached) begin
            if (exp_hit) mhit++;
            else begin
                mmiss++;
                mv[idx] = 1'b1;
                mt[idx] = tag;
            end
        end
        if (flushed) model_clear();
        check_counters();
        @(negedge clk);
    endtask

    task automatic idle_flush();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        model_clear();
        @(negedge clk);
    endtask

    logic [31:0] a, d, h0, m0;
    logic [3:0]  s;
    int          sel, ix, tg;
    bit          seen, stray;

    initial begin
        bus.mem_valid = 1'b0;
        bus.mem_instr = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wstrb = '0;
        bus.bk_ready  = 1'b0;
        bus.bk_rdata  = '0;
        model_clear();

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_mem_ready", 32'(bus.mem_ready), 32'd0);
        check("rst_mem_rdata", bus.mem_rdata, 32'd0);
        check("rst_bk_valid", 32'(bus.bk_valid), 32'd0);
        check("rst_bk_addr", bus.bk_addr, 32'd0);
        check("rst_bk_wdata", bus.bk_wdata, 32'd0);
        check("rst_bk_wstrb", 32'(bus.bk_wstrb), 32'd0);
        check_counters();

        // Cold read, then re-read hit
        bmem[32'h40] = 32'hDEADBEEF;
        txn(32'h40, 4'b0000, 32'h0, 3, 0);
        check("cold_rdata", last_rdata, 32'hDEADBEEF);
        check("cold_miss", miss_count, 32'd1);
        txn(32'h40, 4'b0000, 32'h0, 3, 0);
        check("rehit_rdata", last_rdata, 32'hDEADBEEF);
        check("rehit_hit", hit_count, 32'd1);

        // Conflict on index 16
        txn(32'h140, 4'b0000, 32'h0, 1, 0);
        txn(32'h40, 4'b0000, 32'h0, 0, 0);
        check("conflict_miss", miss_count, 32'd3);

        // Write hit with byte merge, write miss without allocate
        txn(32'h40, 4'b0011, 32'h12345678, 1, 0);
        txn(32'h40, 4'b0000, 32'h0, 1, 0);
        check("merge_rdata", last_rdata, 32'hDEAD5678);
        txn(32'h80, 4'b1111, 32'hA5A5_0F0F, 2, 0);
        m0 = miss_count;
        txn(32'h80, 4'b0000, 32'h0, 2, 0);
        check("wmiss_noalloc", miss_count, m0 + 32'd1);

        // Flush while a fill is outstanding
        txn(32'h44, 4'b0000, 32'h0, 2, 1);
        m0 = miss_count;
        txn(32'h44, 4'b0000, 32'h0, 1, 0);
        check("flush_fill_miss", miss_count, m0 + 32'd1);

        // Cacheable bound: last cached word and first uncached word
        txn(32'hFFC, 4'b0000, 32'h0, 1, 0);
        txn(32'hFFC, 4'b0000, 32'h0, 1, 0);
        h0 = hit_count; m0 = miss_count;
        txn(32'h1000, 4'b0000, 32'h0, 1, 0);
        txn(32'h2000, 4'b0000, 32'h0, 2, 0);
        txn(32'h2000, 4'b0000, 32'h0, 0, 0);
        check("uncached_hits", hit_count, h0);
        check("uncached_miss", miss_count, m0);

        // Stray bk_ready while idle is ignored
        bus.bk_ready = 1'b1;
        @(negedge clk);
        bus.bk_ready = 1'b0;
        check("stray_ready", 32'(bus.mem_ready), 32'd0);
        check("stray_bk_valid", 32'(bus.bk_valid), 32'd0);
        @(negedge clk);

        // Reset in the middle of a write-through
        bus.mem_valid = 1'b1;
        bus.mem_addr  = 32'h40;
        bus.mem_wdata = 32'hCAFE_F00D;
        bus.mem_wstrb = 4'b1111;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = bus.bk_valid;
        end
        check("rstw_bk_seen", 32'(seen), 32'd1);
        rst = 1'b1;
        bus.mem_valid = 1'b0;
        bus.mem_wstrb = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        mhit = 0;
        mmiss = 0;
        check("rstw_bk_valid", 32'(bus.bk_valid), 32'd0);
        check("rstw_mem_ready", 32'(bus.mem_ready), 32'd0);
        check_counters();
        stray = 0;
        repeat (3) begin
            @(negedge clk);
            stray = stray | bus.mem_ready;
        end
        check("rstw_no_ready", 32'(stray), 32'd0);
        txn(32'h40, 4'b0000, 32'h0, 1, 0);
        txn(32'h140, 4'b0000, 32'h0, 1, 0);
        check("rstw_all_miss", miss_count, 32'd2);

        // Randomized traffic over a few contended indices plus uncached space
        for (int k = 0; k < 200; k++) begin
            sel = $urandom_range(0, 9);
            case ($urandom_range(0, 3))
                0: ix = 16;
                1: ix = 17;
                2: ix = 5;
                default: ix = 63;
            endcase
            tg = $urandom_range(0, 3);
            if (sel == 0)      a = 32'h2000 | (32'(ix) << 2);
            else if (sel == 1) a = 32'h1000 | (32'(ix) << 2);
            else               a = (32'(tg) << 8) | (32'(ix) << 2) | 32'($urandom_range(0, 3));
            s = ($urandom_range(0, 9) < 3) ? 4'($urandom_range(1, 15)) : 4'b0000;
            d = $urandom;
            txn(a, s, d, $urandom_range(0, 4), ($urandom_range(0, 9) == 0));
            if ($urandom_range(0, 19) == 0) idle_flush();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dm_cache_ctrl.md
Name: dm_cache_ctrl

Overview:
- Sequencing controller for the 64-entry direct-mapped, one-word-per-line data cache placed between the PicoRV32 native memory port and a slower backing memory.
- Decides hit or miss, issues fills and write-throughs to backing memory over a valid/ready handshake, and returns data to the core with a one-cycle mem_ready pulse.
- Keeps hit and miss counters and supports a whole-cache flush.

Parameters:
- LINES, 64, number of cache lines; must be a power of 2. Index is addr[IDX_W+1:2], tag is addr[31:IDX_W+2].
- IDX_W, 6, log2(LINES).
- CACHE_LIMIT, 32'h0000_1000, byte-address bound. Addresses >= CACHE_LIMIT are uncached and pass straight through.

Ports:
- clk  in  1  system clock; every transition happens on the rising edge.
- rst  in  1  synchronous reset, active-high.
- mem_valid  in  1  core request; held high until mem_ready.
- mem_instr  in  1  instruction fetch flag; treated exactly like a data read.
- mem_addr  in  32  byte address; bits [1:0] are ignored.
- mem_wdata  in  32  write data.
- mem_wstrb  in  4  byte enables; 0 means read.
- mem_ready  out  1  one-cycle completion pulse.
- mem_rdata  out  32  read data; valid while mem_ready=1.
- bk_valid  out  1  backing memory request.
- bk_addr  out  32  backing memory byte address (word aligned).
- bk_wdata  out  32  backing memory write data.
- bk_wstrb  out  4  backing memory byte enables.
- bk_ready  in  1  backing memory completion; bk_rdata is valid in the same cycle.
- bk_rdata  in  32  backing memory read data.
- flush  in  1  pulse requesting that all valid bits be cleared.
- hit_count  out  32  number of cached read hits; wraps.
- miss_count  out  32  number of cached read misses; wraps.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, all line valid bits=0, flush_pend=0.
  - mem_ready=0, mem_rdata=0, bk_valid=0, bk_addr=0, bk_wdata=0, bk_wstrb=0, hit_count=0, miss_count=0.
  - Reset asserted mid-transaction abandons the transaction: bk_valid drops on the next edge and no mem_ready is issued.
- States: IDLE, FILL, WRITE, DONE. All outputs are registered.
- IDLE transitions, in priority order:
  - flush_pend or flush set: clear all valid bits, clear flush_pend, stay in IDLE. Any request waits one cycle.
  - Else, mem_valid with wstrb=0, cached, hit: mem_rdata<=line data, mem_ready<=1, hit_count+1, go to DONE. The pulse is visible exactly 1 cycle after acceptance.
  - Else, mem_valid with wstrb=0 and a miss: bk_valid<=1, bk_addr<={addr[31:2],2'b00}, bk_wstrb<=0, go to FILL. miss_count+1, but only for cached addresses.
  - Else, mem_valid with wstrb!=0: bk_valid<=1 and drive addr/wdata/wstrb to the backing memory, go to WRITE.
  - Writes that hit a cached address byte-merge into the line in the same edge. There is no allocate on write miss. Writes do not change either counter.
- FILL:
  - Hold the bk_* outputs stable until bk_ready.
  - On bk_ready: bk_valid<=0, mem_rdata<=bk_rdata, mem_ready<=1, go to DONE.
  - If cached, also write line data=bk_rdata, set the tag, set valid.
- WRITE: on bk_ready, bk_valid<=0, mem_ready<=1, go to DONE.
- DONE: mem_ready<=0, go to IDLE. mem_ready is therefore exactly one cycle wide, and there is a guaranteed one-cycle bubble before the next acceptance, because the core drops mem_valid after seeing mem_ready.
- Tag compare: line valid AND stored tag == addr[31:IDX_W+2]. Uncached addresses never hit.
- flush in FILL, WRITE or DONE: set flush_pend. The clear is applied in the next IDLE cycle, after the in-flight fill has written its line. That line is also invalidated by the deferred flush.
- bk_ready while not in FILL or WRITE is ignored.
- Counters wrap from 32'hFFFF_FFFF to 0.

Decomposition:
- Shared package or include dm_cache_pkg:
  - state encoding IDLE=2'd0, FILL=2'd1, WRITE=2'd2, DONE=2'd3
  - IDX_W and TAG_W=30-IDX_W
  - CACHE_LIMIT default
- One sub-module, dm_cache_store:
  - tag, data and valid arrays
  - combinational read by index
  - synchronous line write
  - byte-strobe merge
  - flash-clear of all valid bits
- dm_cache_ctrl contains the FSM, the counters and the handshakes.

Test Plan:
- Cold read: rst, then read 0x40, bk_ready 3 cycles after bk_valid with bk_rdata=0xDEADBEEF -> bk_addr=0x40, bk_wstrb=0, mem_rdata=0xDEADBEEF, one-cycle mem_ready, miss_count=1.
- Re-read 0x40 -> mem_ready 1 cycle after acceptance, bk_valid stays 0, mem_rdata=0xDEADBEEF, hit_count=1.
- Conflict: read 0x140 (same index 16, different tag) -> fill issued; a later read of 0x40 misses again, miss_count=3.
- Write hit: write 0x40 with wstrb=4'b0011, wdata=0x12345678 -> bk write carries the same values; a read of 0x40 hits with 0xDEAD5678. Write miss to 0x80 leaves 0x80 uncached, so the next read of 0x80 misses.
- Flush during FILL: flush pulse while waiting on bk_ready -> fill completes and mem_ready fires; the next read of the same address misses.
- Uncached 0x2000 read twice, and rst asserted during WRITE -> each uncached read goes to backing memory and neither counter changes; after rst, bk_valid=0, mem_ready=0, counters=0, and all lines miss.
